pipe_stall_ctrl: RTL

//   Parametrised pipeline hazard controller for the N-stage CPU core. Merges
//   per-stage stall requests, multi-cycle hold requests (divider/multiplier) and

---
 rtl/pipe_stall_ctrl_if.sv | 29 ++
 rtl/pipe_stall_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard-control bundle between the pipeline stage logic and pipe_stall_ctrl.
// The stage logic drives the requests as master; the controller answers as slave.
interface pipe_stall_ctrl_if #(
  parameter int NSTAGE = 6,
  parameter int PC_W   = 32,
  parameter int HOLD_W = 4
);
  logic [NSTAGE-1:0] stallreq;
  logic              hold_req;
  logic [HOLD_W-1:0] hold_cycles;
  logic              excp_req;
  logic [PC_W-1:0]   excp_pc;
  logic [NSTAGE-1:0] stall;
  logic [NSTAGE-1:0] bubble;
  logic              flush;
  logic [PC_W-1:0]   new_pc;
  logic [1:0]        busy_state;
  logic              wdog_err;

  modport master (
    output stallreq, hold_req, hold_cycles, excp_req, excp_pc,
    input  stall, bubble, flush, new_pc, busy_state, wdog_err
  );

  modport slave (
    input  stallreq, hold_req, hold_cycles, excp_req, excp_pc,
    output stall, bubble, flush, new_pc, busy_state, wdog_err
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard controller: merges stall, multi-cycle hold and exception
// requests into per-stage stall/bubble vectors plus a registered redirect flush.
module pipe_stall_ctrl #(
  parameter int NSTAGE     = 6,
  parameter int PC_W       = 32,
  parameter int HOLD_W     = 4,
  parameter int HOLD_STAGE = 3,
  parameter int WDOG_MAX   = 255
) (
  input  logic             clk,
  input  logic             resetn,
  pipe_stall_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int WDOG_W = $clog2(WDOG_MAX + 1);
  localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(WDOG_MAX);

  state_t            state;
  state_t            state_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_cnt_next;
  logic              flush_q;
  logic              flush_next;
  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   pc_next;
  logic [NSTAGE-1:0] eff_req;
  logic [NSTAGE-1:0] req_gated;
  logic [NSTAGE-1:0] stall_mask;
  logic [NSTAGE-1:0] bubble_mask;
  logic              any_req;
  int                top;
  logic [WDOG_W-1:0] wdog_cnt;
  logic [WDOG_W-1:0] wdog_inc;
  logic              wdog_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_RUN;
      hold_cnt <= '0;
      flush_q  <= 1'b0;
      pc_q     <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_cnt_next;
      flush_q  <= flush_next;
      pc_q     <= pc_next;
    end
  end

  // hold_cnt counts the HOLD-state cycles still owed; the accept cycle in RUN
  // is already the first stalled cycle, so a 1-cycle hold never enters HOLD.
  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    flush_next    = 1'b0;
    pc_next       = pc_q;
    eff_req       = '0;
    unique case (state)
      ST_RUN: begin
        eff_req = bus.stallreq;
        if (bus.excp_req) begin
          flush_next = 1'b1;
          pc_next    = bus.excp_pc;
          state_next = ST_FLUSH;
        end else if (bus.hold_req) begin
          eff_req[HOLD_STAGE] = 1'b1;
          if (bus.hold_cycles > HOLD_W'(1)) begin
            hold_cnt_next = bus.hold_cycles - HOLD_W'(1);
            state_next    = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        eff_req             = bus.stallreq;
        eff_req[HOLD_STAGE] = 1'b1;
        if (bus.excp_req) begin
          hold_cnt_next = '0;
          flush_next    = 1'b1;
          pc_next       = bus.excp_pc;
          state_next    = ST_FLUSH;
        end else begin
          hold_cnt_next = hold_cnt - HOLD_W'(1);
          if (hold_cnt <= HOLD_W'(1)) begin
            state_next = ST_RUN;
          end
        end
      end
      ST_FLUSH: begin
        state_next = ST_RUN;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // Requests are masked while reset is asserted so the outputs go quiet at once.
  always_comb begin
    req_gated   = resetn ? eff_req : '0;
    any_req     = 1'b0;
    top         = 0;
    stall_mask  = '0;
    bubble_mask = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      if (req_gated[k]) begin
        any_req = 1'b1;
        top     = k;
      end
    end
    for (int j = 0; j < NSTAGE; j++) begin
      stall_mask[j]  = any_req && (j <= top);
      bubble_mask[j] = any_req && (j == top + 1);
    end
  end

  assign wdog_inc = (wdog_cnt == WDOG_LIM) ? wdog_cnt : wdog_cnt + WDOG_W'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wdog_cnt <= '0;
      wdog_q   <= 1'b0;
    end else if (stall_mask != '0) begin
      wdog_cnt <= wdog_inc;
      if (wdog_inc == WDOG_LIM) begin
        wdog_q <= 1'b1;
      end
    end else begin
      wdog_cnt <= '0;
    end
  end

  assign bus.stall      = stall_mask;
  assign bus.bubble     = bubble_mask;
  assign bus.flush      = flush_q;
  assign bus.new_pc     = pc_q;
  assign bus.busy_state = state;
  assign bus.wdog_err   = wdog_q;

endmodule
